// File: rtl/knn_stream_sequencer_if.sv
// Candidate-stream and result-stream handshake bundle for the k-NN sequencer.
// The sequencer takes the slave side; the point source and result consumer take the master side.
interface knn_stream_sequencer_if #(
  parameter int W = 15,
  parameter int K = 4
);
  localparam int DW = W + 2;

  logic                  cand_valid;
  logic                  cand_ready;
  logic [2*W-1:0]        cand;
  logic                  res_valid;
  logic                  res_ready;
  logic [K*2*W-1:0]      res_points;
  logic [K*DW-1:0]       res_dists;

  modport master (
    output cand_valid, cand, res_ready,
    input  cand_ready, res_valid, res_points, res_dists
  );

  modport slave (
    input  cand_valid, cand, res_ready,
    output cand_ready, res_valid, res_points, res_dists
  );
endinterface

// File: rtl/knn_stream_sequencer.sv
// Runs one k-nearest-neighbour query over a stream of NUM_POINTS candidates,
// keeping a sorted list of the K closest (taxicab distance) and handing it to a consumer.
module knn_stream_sequencer #(
  parameter int W          = 15,
  parameter int K          = 4,
  parameter int NUM_POINTS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*W-1:0]        query,
  input  logic                  abort,
  output logic                  busy,
  knn_stream_sequencer_if.slave bus
);
  localparam int DW = W + 2;
  localparam int CW = $clog2(NUM_POINTS) + 1;
  localparam int PW = 2 * W;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic [PW-1:0]        query_q;
  logic [K-1:0][PW-1:0] pts, pts_ins;
  logic [K-1:0][DW-1:0] dists, dists_ins;
  logic [K-1:0]         closer;
  logic [DW-1:0]        cand_dist;
  logic                 xfer;
  logic                 last;

  function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    return (diff < 0) ? W'(-diff) : W'(diff);
  endfunction

  function automatic logic [DW-1:0] taxicab(input logic [PW-1:0] p, input logic [PW-1:0] q);
    return DW'(abs_diff(p[PW-1:W], q[PW-1:W])) + DW'(abs_diff(p[W-1:0], q[W-1:0]));
  endfunction

  assign cand_dist = taxicab(query_q, bus.cand);
  assign xfer      = bus.cand_valid && (state == RUN);
  assign last      = (count == CW'(NUM_POINTS - 1));

  // The list is kept sorted, so 'closer' is a thermometer code: once set at slot i it
  // stays set for every higher slot. Slot i takes the new entry where the code first
  // rises and takes its lower neighbour's entry everywhere above that.
  always_comb begin
    for (int i = 0; i < K; i++) begin
      closer[i] = cand_dist < dists[i];
    end
    pts_ins[0]   = closer[0] ? bus.cand  : pts[0];
    dists_ins[0] = closer[0] ? cand_dist : dists[0];
    for (int i = 1; i < K; i++) begin
      if (closer[i-1]) begin
        pts_ins[i]   = pts[i-1];
        dists_ins[i] = dists[i-1];
      end else if (closer[i]) begin
        pts_ins[i]   = bus.cand;
        dists_ins[i] = cand_dist;
      end else begin
        pts_ins[i]   = pts[i];
        dists_ins[i] = dists[i];
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    busy           = (state != IDLE);
    bus.cand_ready = (state == RUN);
    bus.res_valid  = (state == DONE);
    bus.res_points = pts;
    bus.res_dists  = dists;
    case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (xfer && last) state_nxt = DONE;
      DONE:    if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Abort freezes the list and count where they are; only a new start clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      query_q <= '0;
      pts     <= '0;
      dists   <= '1;
    end else if (!abort) begin
      if (state == IDLE && start) begin
        query_q <= query;
        count   <= '0;
        pts     <= '0;
        dists   <= '1;
      end else if (xfer) begin
        count   <= count + 1'b1;
        pts     <= pts_ins;
        dists   <= dists_ins;
      end
    end
  end
endmodule

// File: tb/tb_knn_stream_sequencer.sv
// Randomised and directed bench for knn_stream_sequencer against a rank-based reference model.
module tb_knn_stream_sequencer;
  localparam int W  = 4;
  localparam int K  = 2;
  localparam int NP = 4;
  localparam int DW = W + 2;
  localparam int PW = 2 * W;
  localparam int K2 = 4;
  localparam int NP2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [PW-1:0] query = '0;
  logic          busy;
  knn_stream_sequencer_if #(.W(W), .K(K)) bus ();

  knn_stream_sequencer #(.W(W), .K(K), .NUM_POINTS(NP)) dut (
    .clk(clk), .rst(rst), .start(start), .query(query), .abort(abort), .busy(busy), .bus(bus)
  );

  logic          start2 = 1'b0;
  logic          abort2 = 1'b0;
  logic [PW-1:0] query2 = '0;
  logic          busy2;
  knn_stream_sequencer_if #(.W(W), .K(K2)) bus2 ();

  knn_stream_sequencer #(.W(W), .K(K2), .NUM_POINTS(NP2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .query(query2), .abort(abort2), .busy(busy2), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0]   qv;
  logic [PW-1:0]   cands [NP];
  logic [K*PW-1:0] exp_points;
  logic [K*DW-1:0] exp_dists;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: candidate j lands in slot = number of candidates that are strictly
  // closer, or equally close and earlier; anything ranked K or beyond is absent.
  task automatic model();
    int d [NP];
    int rank;
    int dx, dy;
    for (int j = 0; j < NP; j++) begin
      dx = int'(qv[PW-1:W]) - int'(cands[j][PW-1:W]);
      dy = int'(qv[W-1:0])  - int'(cands[j][W-1:0]);
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      d[j] = dx + dy;
    end
    exp_points = '0;
    exp_dists  = '1;
    for (int j = 0; j < NP; j++) begin
      rank = 0;
      for (int i = 0; i < NP; i++)
        if (d[i] < d[j] || (d[i] == d[j] && i < j)) rank++;
      if (rank < K) begin
        exp_points[rank*PW +: PW] = cands[j];
        exp_dists[rank*DW +: DW]  = DW'(d[j]);
      end
    end
  endtask

  task automatic check_result(input string tag);
    check({tag, "_pts"},  64'(bus.res_points), 64'(exp_points));
    check({tag, "_dist"}, 64'(bus.res_dists),  64'(exp_dists));
  endtask

  task automatic start_query(input string tag);
    query = qv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_load_busy"}, 64'(busy), 64'd1);
    check({tag, "_load_rdy"},  64'(bus.cand_ready), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic feed(input string tag, input int n, input bit gaps);
    int  idx = 0;
    int  cyc = 0;
    bit  go;
    while (idx < n && cyc < 100) begin
      bus.cand_valid = gaps ? (cyc % 3 == 0) : 1'b1;
      bus.cand       = bus.cand_valid ? cands[idx] : PW'($urandom);
      go             = bus.cand_valid && bus.cand_ready;
      @(posedge clk); #1;
      if (go) idx++;
      cyc++;
    end
    bus.cand_valid = 1'b0;
    bus.cand       = PW'($urandom);
    check({tag, "_feed_count"}, 64'(idx), 64'(n));
  endtask

  task automatic finish_query(input string tag, input int hold);
    check({tag, "_latency_vld"}, 64'(bus.res_valid), 64'd1);
    check({tag, "_done_rdy"},    64'(bus.cand_ready), 64'd0);
    check_result(tag);
    for (int h = 0; h < hold; h++) begin
      bus.res_ready = 1'b0;
      start = 1'($urandom);
      query = PW'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, 64'(bus.res_valid), 64'd1);
      check_result({tag, "_hold"});
    end
    bus.res_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    start = 1'b0;
    check({tag, "_post_vld"},  64'(bus.res_valid), 64'd0);
    check({tag, "_post_busy"}, 64'(busy), 64'd0);
    check_result({tag, "_kept"});
  endtask

  task automatic run_query(input string tag, input bit gaps, input int hold);
    model();
    start_query(tag);
    feed(tag, NP, gaps);
    finish_query(tag, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cand_valid  = 1'b0;
    bus.cand        = '0;
    bus.res_ready   = 1'b0;
    bus2.cand_valid = 1'b0;
    bus2.cand       = '0;
    bus2.res_ready  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_rdy",   64'(bus.cand_ready), 64'd0);
    check("rst_vld",   64'(bus.res_valid), 64'd0);
    check("rst_pts",   64'(bus.res_points), 64'd0);
    check("rst_dists", 64'(bus.res_dists), 64'(12'hFFF));
    rst = 1'b1;
    @(posedge clk); #1;

    qv = {4'd5, 4'd5};
    cands[0] = {4'd0, 4'd0}; cands[1] = {4'd6, 4'd5};
    cands[2] = {4'd5, 4'd7}; cands[3] = {4'd9, 4'd9};
    run_query("basic", 1'b0, 0);
    check("basic_const_pts",  64'(bus.res_points), 64'(16'h5765));
    check("basic_const_dist", 64'(bus.res_dists),  64'(12'h081));

    cands[0] = {4'd4, 4'd5}; cands[1] = {4'd6, 4'd5};
    cands[2] = {4'd5, 4'd4}; cands[3] = {4'd0, 4'd0};
    run_query("ties", 1'b0, 1);
    check("ties_const_pts",  64'(bus.res_points), 64'(16'h6545));
    check("ties_const_dist", 64'(bus.res_dists),  64'(12'h041));

    cands[0] = {4'd0, 4'd0}; cands[1] = {4'd6, 4'd5};
    cands[2] = {4'd5, 4'd7}; cands[3] = {4'd9, 4'd9};
    run_query("bp", 1'b1, 5);

    start_query("rstmid");
    feed("rstmid", 2, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("rstmid_busy",  64'(busy), 64'd0);
    check("rstmid_rdy",   64'(bus.cand_ready), 64'd0);
    check("rstmid_vld",   64'(bus.res_valid), 64'd0);
    check("rstmid_pts",   64'(bus.res_points), 64'd0);
    check("rstmid_dists", 64'(bus.res_dists), 64'(12'hFFF));
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    qv = PW'($urandom);
    for (int j = 0; j < NP; j++) cands[j] = PW'($urandom);
    run_query("after_rst", 1'b0, 2);

    qv = {4'd3, 4'd3};
    cands[0] = {4'd3, 4'd3};
    start_query("abort");
    feed("abort", 1, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("abort_vld", 64'(bus.res_valid), 64'd0);
    end
    qv = {4'd3, 4'd3};
    for (int j = 0; j < NP; j++) cands[j] = {4'(8 + j), 4'($urandom_range(8, 15))};
    run_query("after_abort", 1'b0, 0);

    qv = {4'd15, 4'd15};
    for (int j = 0; j < NP; j++) cands[j] = {4'd0, 4'd0};
    run_query("extreme", 1'b0, 0);
    check("extreme_const_dist", 64'(bus.res_dists), 64'(12'h79E));

    for (int r = 0; r < 8; r++) begin
      qv = PW'($urandom);
      for (int j = 0; j < NP; j++) cands[j] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7))};
      run_query("rand", 1'($urandom), int'($urandom_range(0, 3)));
    end

    query2 = {4'd15, 4'd15};
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    @(posedge clk); #1;
    bus2.cand_valid = 1'b1;
    bus2.cand = {4'd0, 4'd0};
    @(posedge clk); #1;
    bus2.cand = {4'd15, 4'd14};
    @(posedge clk); #1;
    bus2.cand_valid = 1'b0;
    check("k4_vld",   64'(bus2.res_valid), 64'd1);
    check("k4_pts",   64'(bus2.res_points), 64'(32'h0000_00FE));
    check("k4_dists", 64'(bus2.res_dists), 64'(24'hFFF781));
    bus2.res_ready = 1'b1;
    @(posedge clk); #1;
    bus2.res_ready = 1'b0;
    check("k4_post_vld", 64'(bus2.res_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
